bn_stats_accum: RTL and testbench
=================================

Name: bn_stats_accum

Overview:
- Producer side of the batch-norm datapath. It consumes a stream of N-bit activation samples x_i and accumulates sum and sum-of-squares over a batch of 2^LOG_BATCH samples.
- At the end of each batch it emits batch mean and variance over a valid/ready handshake. These outputs feed the mean and variance operands of the batch-norm core.
- It applies backpressure on its input while a result is waiting to be consumed.

Parameters:
- N, 16, sample width (unsigned).
- LOG_BATCH, 2, log2 of samples per batch (batch size 2^LOG_BATCH); legal range 1..8.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; discards the partial batch and any held result.
- in_xi  in  N  sample x_i.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- stat_mean  out  N  batch mean.
- stat_var  out  2N  batch variance.
- stat_valid  out  1  mean/var valid.
- stat_ready  in  1  consumer accepts the result.
- batch_cnt  out  LOG_BATCH  samples accepted in the current batch.

Behaviour:
- Reset (async, reset_n=0): all outputs are 0.
  - state=ACC; sum, sumsq and batch_cnt cleared.
  - in_ready=1 one cycle after reset_n deasserts (registered).
- Accumulator widths:
  - sum: N+LOG_BATCH bits.
  - sumsq: 2N+LOG_BATCH bits.
  - No overflow is possible at any legal parameter value.
- State ACC:
  - in_ready=1.
  - Accept on in_valid & in_ready at a rising edge: sum+=x, sumsq+=x*x, batch_cnt+=1.
  - After the accept with batch_cnt == 2^LOG_BATCH-1, batch_cnt wraps to 0 and the state goes to MEAN.
- State MEAN (1 cycle):
  - in_ready=0.
  - mean_r = sum >> LOG_BATCH (truncating).
  - ex2_r = sumsq >> LOG_BATCH (truncating).
  - Go to VAR.
- State VAR (1 cycle):
  - in_ready=0.
  - stat_var <= ex2_r - mean_r*mean_r (2N-bit unsigned).
  - The result is never negative, because floor(E[x^2]) >= floor(mean)^2; an assertion checks this.
  - stat_mean <= mean_r; stat_valid <= 1; sum and sumsq cleared; go to HOLD.
- Latency: last sample accepted at edge k gives stat_valid high after edge k+2.
- State HOLD:
  - in_ready=0.
  - stat_mean and stat_var stable while stat_valid=1 and stat_ready=0.
  - On stat_valid & stat_ready at an edge: stat_valid<=0, go to ACC, in_ready=1 the next cycle.
  - Samples presented in HOLD are not accepted.
- clear=1 at an edge:
  - Any state goes to ACC.
  - sum, sumsq, batch_cnt and stat_valid cleared.
  - stat_mean and stat_var hold their last values.
  - clear has priority over a simultaneous accept or handshake.
- Reset mid-batch: the partial batch is lost and no result is emitted.
- in_valid is not required to be continuous; gaps stretch the batch arbitrarily.

Optional Feature:
- Macro: BN_STATS_MINMAX_EN.
- Defined:
  - Adds outputs stat_min (N) and stat_max (N): per-batch running min and max of accepted samples.
  - Running min resets to all-ones, running max to 0, at batch start, clear and reset.
  - stat_min and stat_max register with stat_mean and hold under the same handshake.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bn_pkg holds:
  - the state enum {ACC, MEAN, VAR, HOLD};
  - default N and LOG_BATCH localparams;
  - width helper constants (SUM_W = N+LOG_BATCH, SQ_W = 2N+LOG_BATCH).
- One sub-module, bn_square: combinational N x N unsigned multiply giving 2N bits.
  - Instanced twice: x*x in ACC and mean_r*mean_r in VAR.

Test Plan:
- LOG_BATCH=2, samples 2,4,6,8 with in_valid continuous -> stat_mean=5, stat_var=5 (120>>2=30, 30-25); stat_valid rises 2 edges after the 4th accept.
- Samples 4,5,6,5 with stat_ready held low 5 cycles -> stat_mean=5, stat_var=0 (102>>2=25); in_ready=0 and values stable throughout HOLD; the next batch starts after the handshake.
- Samples 1,2,2,2 -> stat_mean=1 (truncated 7>>2), stat_var=2 (13>>2=3, 3-1); in_valid gaps of 1-3 cycles between samples change nothing.
- All samples 65535 -> stat_mean=65535, stat_var=0, no overflow.
- clear asserted after 2 of 4 samples, then samples 2,4,6,8 -> result matches the first scenario; reset_n pulsed mid-batch -> all outputs 0 and no stat_valid.
- With BN_STATS_MINMAX_EN, samples 7,3,9,1 -> stat_min=1, stat_max=9, stat_mean=5, stat_var=10 (140>>2=35, 35-25).

Source files
------------

// File: rtl/bn_pkg.sv
// bn_pkg: shared state encoding, default parameters and accumulator width helpers
package bn_pkg;
  typedef enum logic [1:0] {ACC, MEAN, VAR, HOLD} state_t;
  localparam int N_DEF = 16;
  localparam int LOG_BATCH_DEF = 2;
  function automatic int sum_w(input int n, input int lb);
    return n + lb;
  endfunction
  function automatic int sq_w(input int n, input int lb);
    return 2 * n + lb;
  endfunction
  localparam int SUM_W = sum_w(N_DEF, LOG_BATCH_DEF);
  localparam int SQ_W = sq_w(N_DEF, LOG_BATCH_DEF);
endpackage

// File: rtl/bn_square.sv
// bn_square: combinational unsigned square, N bits in, 2N bits out
module bn_square #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a_i,
  output logic [2*N-1:0] p_o
);
  assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, a_i};
endmodule

// File: rtl/bn_stats_accum.sv
// bn_stats_accum: batch mean/variance over 2^LOG_BATCH samples with valid/ready output.
// Define BN_STATS_MINMAX_EN to add per-batch stat_min/stat_max outputs.
module bn_stats_accum
  import bn_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG_BATCH = LOG_BATCH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [N-1:0]         in_xi,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         stat_mean,
  output logic [2*N-1:0]       stat_var,
  output logic                 stat_valid,
  input  logic                 stat_ready,
  output logic [LOG_BATCH-1:0] batch_cnt
`ifdef BN_STATS_MINMAX_EN
  ,
  output logic [N-1:0]         stat_min,
  output logic [N-1:0]         stat_max
`endif
);
  localparam int SW = sum_w(N, LOG_BATCH);
  localparam int QW = sq_w(N, LOG_BATCH);
  state_t               state_q;
  logic [SW-1:0]        sum_q;
  logic [QW-1:0]        sumsq_q;
  logic [LOG_BATCH-1:0] cnt_q;
  logic [N-1:0]         mean_q, smean_q;
  logic [2*N-1:0]       ex2_q, svar_q, x_sq, m_sq;
  logic                 valid_q, rdy_q, acc;
  bn_square #(.N(N)) u_sq_x (.a_i(in_xi), .p_o(x_sq));
  bn_square #(.N(N)) u_sq_m (.a_i(mean_q), .p_o(m_sq));
  assign acc = in_valid & rdy_q & (state_q == ACC);
  assign in_ready = rdy_q;
  assign stat_mean = smean_q;
  assign stat_var = svar_q;
  assign stat_valid = valid_q;
  assign batch_cnt = cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ACC;
      sum_q <= '0;
      sumsq_q <= '0;
      cnt_q <= '0;
      mean_q <= '0;
      ex2_q <= '0;
      smean_q <= '0;
      svar_q <= '0;
      valid_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (clear) begin
      state_q <= ACC;
      sum_q <= '0;
      sumsq_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      case (state_q)
        ACC: begin
          rdy_q <= !(acc && (&cnt_q));
          if (acc) begin
            sum_q <= sum_q + SW'(in_xi);
            sumsq_q <= sumsq_q + QW'(x_sq);
            cnt_q <= cnt_q + LOG_BATCH'(1);
            if (&cnt_q) state_q <= MEAN;
          end
        end
        MEAN: begin
          mean_q <= sum_q[SW-1:LOG_BATCH];
          ex2_q <= sumsq_q[QW-1:LOG_BATCH];
          state_q <= VAR;
        end
        VAR: begin
          svar_q <= ex2_q - m_sq;
          smean_q <= mean_q;
          valid_q <= 1'b1;
          sum_q <= '0;
          sumsq_q <= '0;
          state_q <= HOLD;
        end
        HOLD: if (stat_ready) begin
          valid_q <= 1'b0;
          rdy_q <= 1'b1;
          state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  // floor(E[x^2]) >= floor(mean)^2 always, so the subtraction never wraps
  a_var_nonneg: assert property (@(posedge clk) disable iff (!reset_n) state_q == VAR |-> ex2_q >= m_sq);
`ifdef BN_STATS_MINMAX_EN
  logic [N-1:0] min_q, max_q, smin_q, smax_q;
  assign stat_min = smin_q;
  assign stat_max = smax_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      min_q <= '1;
      max_q <= '0;
      smin_q <= '0;
      smax_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (acc) begin
      min_q <= (in_xi < min_q) ? in_xi : min_q;
      max_q <= (in_xi > max_q) ? in_xi : max_q;
    end else if (state_q == VAR) begin
      smin_q <= min_q;
      smax_q <= max_q;
      min_q <= '1;
      max_q <= '0;
    end
`endif
endmodule

// File: tb/tb_bn_stats_accum.sv
// tb_bn_stats_accum: table-driven and randomized checks of bn_stats_accum (N=16, LOG_BATCH=2)
module tb_bn_stats_accum;
  logic        clk = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0, stat_ready = 1'b0;
  logic [15:0] in_xi = '0;
  logic        in_ready, stat_valid;
  logic [15:0] stat_mean;
  logic [31:0] stat_var;
  logic [1:0]  batch_cnt;
`ifdef BN_STATS_MINMAX_EN
  logic [15:0] stat_min, stat_max;
`endif
  int checks = 0, errors = 0;

  bn_stats_accum #(.N(16), .LOG_BATCH(2)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_xi(in_xi), .in_valid(in_valid),
    .in_ready(in_ready), .stat_mean(stat_mean), .stat_var(stat_var), .stat_valid(stat_valid),
    .stat_ready(stat_ready), .batch_cnt(batch_cnt)
`ifdef BN_STATS_MINMAX_EN
    , .stat_min(stat_min), .stat_max(stat_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] s;
    int gap;
    int hold;
    longint em, ev, emin, emax;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // reference: straight arithmetic on the batch of samples
  function automatic void model(input logic [3:0][15:0] s, output longint m, output longint v,
                                output longint mn, output longint mx);
    longint sum = 0, sq = 0;
    mn = 65535;
    mx = 0;
    for (int i = 0; i < 4; i++) begin
      sum += longint'(s[i]);
      sq += longint'(s[i]) * longint'(s[i]);
      if (longint'(s[i]) < mn) mn = longint'(s[i]);
      if (longint'(s[i]) > mx) mx = longint'(s[i]);
    end
    m = sum / 4;
    v = sq / 4 - m * m;
  endfunction

  task automatic push(input logic [15:0] x);
    int n = 0;
    @(negedge clk);
    in_xi = x;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", longint'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stat_valid && n < 20);
  endtask

  task automatic run_batch(input vec_t v);
    int n;
    logic [15:0] m0;
    logic [31:0] v0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && v.gap > 0) repeat ($urandom_range(1, v.gap)) @(negedge clk);
      push(v.s[i]);
    end
    wait_valid(n);
    chk("latency", n, 3);
    chk("mean", longint'(stat_mean), v.em);
    chk("var", longint'(stat_var), v.ev);
`ifdef BN_STATS_MINMAX_EN
    chk("min", longint'(stat_min), v.emin);
    chk("max", longint'(stat_max), v.emax);
`endif
    chk("hold_in_ready", longint'(in_ready), 0);
    m0 = stat_mean;
    v0 = stat_var;
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      in_xi = 16'($urandom);
      @(negedge clk);
      chk("hold_mean", longint'(stat_mean), longint'(m0));
      chk("hold_var", longint'(stat_var), longint'(v0));
      chk("hold_valid", longint'(stat_valid), 1);
      chk("hold_ready", longint'(in_ready), 0);
      chk("hold_cnt", longint'(batch_cnt), 0);
    end
    in_valid = 1'b0;
    stat_ready = 1'b1;
    @(posedge clk);
    #1 stat_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", longint'(stat_valid), 0);
    chk("post_hs_ready", longint'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t r;
    int n;
    tbl[0] = '{s: {16'd8, 16'd6, 16'd4, 16'd2}, gap: 0, hold: 0, em: 5, ev: 5, emin: 2, emax: 8};
    tbl[1] = '{s: {16'd5, 16'd6, 16'd5, 16'd4}, gap: 0, hold: 5, em: 5, ev: 0, emin: 4, emax: 6};
    tbl[2] = '{s: {16'd2, 16'd2, 16'd2, 16'd1}, gap: 3, hold: 1, em: 1, ev: 2, emin: 1, emax: 2};
    tbl[3] = '{s: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, gap: 0, hold: 2, em: 65535, ev: 0,
               emin: 65535, emax: 65535};
    tbl[4] = '{s: {16'd1, 16'd9, 16'd3, 16'd7}, gap: 1, hold: 0, em: 5, ev: 10, emin: 1, emax: 9};
    #1;
    chk("rst_mean", longint'(stat_mean), 0);
    chk("rst_var", longint'(stat_var), 0);
    chk("rst_valid", longint'(stat_valid), 0);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_cnt", longint'(batch_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rel_ready0", longint'(in_ready), 0);
    @(negedge clk);
    chk("rel_ready1", longint'(in_ready), 1);
    for (int i = 0; i < 5; i++) run_batch(tbl[i]);
    // clear mid-batch: partial batch dropped, held mean retained
    push(16'd100);
    push(16'd200);
    chk("cnt_before_clear", longint'(batch_cnt), 2);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_cnt", longint'(batch_cnt), 0);
    chk("clear_mean_held", longint'(stat_mean), 5);
    chk("clear_var_held", longint'(stat_var), 10);
    chk("clear_ready", longint'(in_ready), 1);
    run_batch(tbl[0]);
    // clear beats a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1;
    in_xi = 16'd500;
    clear = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_vs_accept_cnt", longint'(batch_cnt), 0);
    // clear while a result is held
    for (int i = 0; i < 4; i++) push(16'd10);
    wait_valid(n);
    chk("hold_pre_clear_valid", longint'(stat_valid), 1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_hold_valid", longint'(stat_valid), 0);
    chk("clear_hold_mean", longint'(stat_mean), 10);
    chk("clear_hold_ready", longint'(in_ready), 1);
    run_batch(tbl[4]);
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: r.s[i] = 16'd0;
          1: r.s[i] = 16'hFFFF;
          default: r.s[i] = 16'($urandom);
        endcase
      end
      r.gap = $urandom_range(0, 2);
      r.hold = $urandom_range(0, 3);
      model(r.s, r.em, r.ev, r.emin, r.emax);
      run_batch(r);
    end
    // reset mid-batch: no result emitted, outputs zeroed
    push(16'd300);
    push(16'd400);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mean", longint'(stat_mean), 0);
    chk("mid_rst_var", longint'(stat_var), 0);
    chk("mid_rst_valid", longint'(stat_valid), 0);
    chk("mid_rst_ready", longint'(in_ready), 0);
    chk("mid_rst_cnt", longint'(batch_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_valid", longint'(stat_valid), 0);
    chk("mid_rst_cnt_after", longint'(batch_cnt), 0);
    r.s = {16'd3, 16'd3, 16'd1, 16'd1};
    r.gap = 0;
    r.hold = 1;
    r.em = 2;
    r.ev = 1;
    r.emin = 1;
    r.emax = 3;
    run_batch(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
